// File: rtl/wide_add_seq.sv
// Multi-cycle WORDS x 16-bit add/subtract sequencer, one slice per cycle, LSB first.
// Optional signed-overflow flag is built only when WIDE_ADD_OVF_EN is defined.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                carry_out,
  output logic                overflow
);

  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [KW-1:0] k;
  logic          carry;
  logic [W-1:0]  a_q, b_q;
  logic [15:0]   a_slice, b_slice;
  logic [16:0]   slice_sum;
  logic          accept, last;

  assign accept    = in_valid && (state == IDLE);
  assign last      = (k == K_LAST);
  assign a_slice   = a_q[k*16 +: 16];
  assign b_slice   = b_q[k*16 +: 16];
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {16'd0, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are plain data holding registers; subtraction stores ~B and seeds carry with 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= sub ? ~op_b : op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      carry <= sub;
    end else if (state == RUN) begin
      result[k*16 +: 16] <= slice_sum[15:0];
      carry              <= slice_sum[16];
      k                  <= last ? '0 : k + 1'b1;
      if (last) carry_out <= slice_sum[16];
    end
  end

`ifdef WIDE_ADD_OVF_EN
  logic ovf_q;

  // On the final slice, slice_sum[15] is the new result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= (a_q[W-1] == b_q[W-1]) && (slice_sum[15] != a_q[W-1]);
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq (WORDS=4): vector table with scoreboard queue plus
// hand-written backpressure and reset-abort sequences.
module tb_wide_add_seq;

  localparam int W = 64;
`ifdef WIDE_ADD_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] op_a, op_b, result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  wide_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input exp_t e, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", in_ready, 1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_lat, output exp_t got);
    int lat;
    exp_t e;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, lat, exp_lat);
    got.res = result; got.co = carry_out; got.ov = overflow;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_result"}, result, e.res);
      check({name, "_carry"}, carry_out, e.co);
      check({name, "_overflow"}, overflow, e.ov);
    end else begin
      check({name, "_scoreboard_nonempty"}, 0, 1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    e.res = v.res; e.co = v.co; e.ov = v.ov;
    out_ready = 1'b1;
    start_op(v.a, v.b, v.s, e, 1'b1);
    wait_out(v.name, 4, got);
    @(posedge clk);
    #1;
    check({v.name, "_out_valid_one_cycle"}, out_valid, 0);
    check({v.name, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    exp_t e, got;
    bit   seen;

    vecs[0] = '{"carry_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{"full_wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow",  64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub_noborrow",64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4] = '{"pos_ovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, OVF};
    vecs[5] = '{"neg_ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, OVF};
    vecs[6] = '{"neg_ovf_add", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, OVF};

    in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; op_a = '0; op_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_carry", carry_out, 0);
    check("reset_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure with an ignored in_valid pulse during RUN.
    out_ready = 1'b0;
    e.res = 64'h1234_5678_9ABC_DF00; e.co = 1'b0; e.ov = 1'b0;
    start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, e, 1'b1);
    @(negedge clk);
    op_a = 64'hDEAD_BEEF_DEAD_BEEF; op_b = 64'h5555_5555_5555_5555; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("backpressure", 3, got);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_hold", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_result_stable", result, e.res);
      check("bp_carry_stable", carry_out, e.co);
      check("bp_overflow_stable", overflow, e.ov);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_out_valid_released", out_valid, 0);
    check("bp_in_ready_rises", in_ready, 1);

    // Reset during slice 2 aborts the operation.
    e.res = 64'h3; e.co = 1'b0; e.ov = 1'b0;
    start_op(64'h1, 64'h2, 1'b0, e, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    check("abort_overflow", overflow, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);
    run_vec('{"after_abort", 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0});

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle, multi-precision add/subtract sequencer for the ALU datapath. Takes two WORDS×16-bit operands over a valid/ready handshake and processes one 16-bit slice per cycle, least significant first, using an internal 16-bit ripple slice with carry-in. The carry is chained through a register between slices. The block sits directly in front of the ALU result path and produces a wide sum, a final carry and an optional signed-overflow flag.

## Interface
- WORDS, default 4: number of 16-bit slices. Must be ≥1. Total width W = 16*WORDS.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept; high only in IDLE.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  sum or difference, modulo 2^W.
- carry_out  output  1  carry out of bit W−1. For subtract, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow (see Configuration).

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: processes slices using a counter k = 0..WORDS−1; counter width max(1, clog2(WORDS)).
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready:
  - Latch op_a, op_b (op_b inverted if sub) and sub.
  - Carry register ← sub. k ← 0.
- RUN, each cycle:
  - Add slice k of A and B' with the carry register to give a 16-bit sum s and carry c.
  - result[16k+15:16k] ← s; carry register ← c; k ← k+1.
  - When k=WORDS−1: carry_out ← c, compute overflow, go to DONE.
- DONE→IDLE on out_ready. A new operand cannot be accepted in the same cycle; in_ready rises the cycle after.
- Overflow rule: overflow = (A[W−1] == B'[W−1]) && (result[W−1] != A[W−1]). B' is op_b after the optional inversion.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- result, carry_out and overflow are meaningful only while out_valid=1. They hold their values in IDLE. Upper slices of result keep stale data until RUN rewrites them.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, k=0, carry register=0.
  - in_ready=1, out_valid=0.
  - result=0, carry_out=0, overflow=0.
- Latency: if the accept edge is E, out_valid is high after edge E+WORDS. With WORDS=1, out_valid is high the cycle after accept.
- Throughput: one operation per WORDS+2 cycles at best, with out_ready held high.
- out_valid and the result outputs stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-RUN or in DONE aborts the operation. No out_valid is produced; outputs return to reset values.
- If out_ready is high when DONE is entered, the handshake completes on the first DONE cycle, so out_valid lasts exactly one cycle.

## Configuration
- WIDE_ADD_OVF_EN:
  - Defined: the overflow register and logic are implemented as described above.
  - Undefined: overflow is tied to 0 and no overflow logic or register is generated. All other behaviour is unchanged.

## Test plan
All scenarios use WORDS=4.
- Carry across slices: op_a=0x0000_0000_0000_FFFF, op_b=0x1, sub=0 → result=0x0000_0000_0001_0000, carry_out=0, overflow=0. out_valid rises 4 cycles after the accept edge.
- Full wrap: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0x1 → result=0, carry_out=1, overflow=0.
- Subtract with borrow: op_a=0x5, op_b=0x7, sub=1 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0. Then op_a=0x7, op_b=0x5, sub=1 → result=0x2, carry_out=1.
- Signed overflow: op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=0x1 → result=0x8000_0000_0000_0000, carry_out=0. overflow=1 with WIDE_ADD_OVF_EN defined, 0 without.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0. Pulse in_valid with new operands during RUN → no effect on the result. in_ready rises the cycle after out_ready.
- Reset mid-operation: drop rst_n during RUN slice 2 → outputs go to reset values immediately and no out_valid follows. After release, an operation of 0x1+0x1 completes with result=0x2.
